// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel (AR/R) between inst-fetch and data-load requesters.
// Define ARB_ROUND_ROBIN_EN for round-robin collision arbitration; default is fixed data priority.
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rlast,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LEN_W-1:0]  d_len,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rlast,
    output logic              rd_err,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    state_t         state;
    logic [LEN_W:0] cnt;
    logic           pick_d, own_d, ar_hs, beat;

    assign own_d = arid[0];
    assign ar_hs = arvalid && arready;
    assign beat  = rready && rvalid;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner;
    assign pick_d = d_req && (!i_req || !last_owner);
    always_ff @(posedge clk or posedge rst)
        if (rst) last_owner <= 1'b0;
        else if (ar_hs) last_owner <= own_d;
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            arid    <= '0;
            araddr  <= '0;
            arlen   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (i_req || d_req) begin
                    state   <= AR;
                    arvalid <= 1'b1;
                    arid    <= {3'b000, pick_d};
                    araddr  <= pick_d ? d_addr : i_addr;
                    arlen   <= pick_d ? d_len : i_len;
                end
                AR: if (arready) begin
                    state   <= R;
                    arvalid <= 1'b0;
                    rready  <= 1'b1;
                    cnt     <= '0;
                end
                R: if (rvalid) begin
                    cnt <= cnt + 1'b1;
                    if (rlast) begin
                        state  <= IDLE;
                        rready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign i_gnt    = ar_hs && !own_d;
    assign d_gnt    = ar_hs && own_d;
    assign i_rvalid = beat && !own_d;
    assign d_rvalid = beat && own_d;
    assign i_rlast  = i_rvalid && rlast;
    assign d_rlast  = d_rvalid && rlast;
    assign i_rdata  = i_rvalid ? rdata : '0;
    assign d_rdata  = d_rvalid ? rdata : '0;
    // cnt is the index of the current beat, so a well-formed last beat has cnt == arlen
    assign rd_err   = beat && (rresp != 2'b00 || (rlast ? cnt != {1'b0, arlen} : cnt == {1'b0, arlen}));

    rid_match: assert property (@(posedge clk) disable iff (rst) beat |-> rid == arid);
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed checks of arbitration, AR handshake, R steering, error pulses and reset.
module tb_axi_rd_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clk, rst;
    logic        i_req, d_req, i_gnt, d_gnt, i_rvalid, d_rvalid, i_rlast, d_rlast, rd_err;
    logic [31:0] i_addr, d_addr, i_rdata, d_rdata, araddr, rdata;
    logic [7:0]  i_len, d_len, arlen;
    logic [3:0]  arid, rid;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    int          n_cmp = 0;
    int          n_err = 0;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
        .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
        .rd_err(rd_err), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] data, input logic last, input logic [1:0] resp, input logic [3:0] id);
        @(negedge clk);
        rvalid = 1'b1; rdata = data; rlast = last; rresp = resp; rid = id;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        #1;
    endtask

    initial begin
        logic ed;
        rst = 1'b1;
        i_req = 0; i_addr = '0; i_len = '0;
        d_req = 0; d_addr = '0; d_len = '0;
        arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        @(negedge clk); #1;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_arid", arid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_gnt", {i_gnt, d_gnt}, 0);
        chk("rst_rd_err", rd_err, 0);
        @(negedge clk); rst = 1'b0;

        // single inst burst of 4 beats
        @(negedge clk); i_req = 1; i_addr = 32'hBFC0_0000; i_len = 8'd3; arready = 1; #1;
        chk("t1_arvalid_pre", arvalid, 0);
        @(negedge clk); #1;
        chk("t1_arvalid", arvalid, 1);
        chk("t1_arid", arid, 0);
        chk("t1_araddr", araddr, 32'hBFC0_0000);
        chk("t1_arlen", arlen, 3);
        chk("t1_arsize", arsize, 3'b010);
        chk("t1_arburst", arburst, 2'b01);
        chk("t1_i_gnt", i_gnt, 1);
        chk("t1_d_gnt", d_gnt, 0);
        i_req = 0;
        @(negedge clk); #1;
        chk("t1_arvalid_drop", arvalid, 0);
        chk("t1_rready", rready, 1);
        chk("t1_i_gnt_end", i_gnt, 0);
        for (int k = 0; k < 4; k++) begin
            beat(32'hC0DE_0000 + k, k == 3, 2'b00, 4'd0);
            chk("t1_i_rvalid", i_rvalid, 1);
            chk("t1_i_rdata", i_rdata, 32'hC0DE_0000 + k);
            chk("t1_i_rlast", i_rlast, k == 3);
            chk("t1_d_rvalid", d_rvalid, 0);
            chk("t1_rd_err", rd_err, 0);
        end
        idle();
        chk("t1_rready_end", rready, 0);
        chk("t1_i_rvalid_end", i_rvalid, 0);

        // collision: data first, inst after one idle cycle
        @(negedge clk); i_req = 1; d_req = 1; i_addr = 32'h1000; i_len = 0; d_addr = 32'h2000; d_len = 0;
        @(negedge clk); #1;
        chk("t2_arid_d", arid, 1);
        chk("t2_araddr_d", araddr, 32'h2000);
        chk("t2_d_gnt", d_gnt, 1);
        chk("t2_i_gnt_lose", i_gnt, 0);
        d_req = 0;
        beat(32'hD0, 1, 2'b00, 4'd1);
        chk("t2_d_rvalid", d_rvalid, 1);
        chk("t2_d_rdata", d_rdata, 32'hD0);
        chk("t2_d_rlast", d_rlast, 1);
        chk("t2_i_rvalid", i_rvalid, 0);
        chk("t2_i_rdata", i_rdata, 0);
        idle();
        chk("t2_gap", arvalid, 0);
        @(negedge clk); #1;
        chk("t2_arvalid_i", arvalid, 1);
        chk("t2_arid_i", arid, 0);
        chk("t2_araddr_i", araddr, 32'h1000);
        chk("t2_i_gnt", i_gnt, 1);
        i_req = 0;
        beat(32'h1E, 1, 2'b00, 4'd0);
        chk("t2_i_rvalid2", i_rvalid, 1);
        chk("t2_d_rvalid2", d_rvalid, 0);
        idle();

        // both requests held for four bursts
        @(negedge clk); i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h200;
        for (int b = 0; b < 4; b++) begin
            ed = RR ? (b % 2 == 0) : 1'b1;
            @(negedge clk); #1;
            chk("t3_arvalid", arvalid, 1);
            chk("t3_arid", arid, {3'b000, ed});
            chk("t3_araddr", araddr, ed ? 32'h200 : 32'h100);
            chk("t3_d_gnt", d_gnt, ed);
            chk("t3_i_gnt", i_gnt, !ed);
            beat(32'h300 + b, 1, b == 2 ? 2'b01 : 2'b00, {3'b000, ed});
            chk("t3_rd_err", rd_err, b == 2);
            chk("t3_d_rvalid", d_rvalid, ed);
            if (b == 3) begin i_req = 0; d_req = 0; end
            idle();
        end

        // AR stall then an early rlast carrying an error response
        @(negedge clk); d_req = 1; d_addr = 32'h3000_0040; d_len = 1; arready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("t4_arvalid", arvalid, 1);
            chk("t4_araddr", araddr, 32'h3000_0040);
            chk("t4_arlen", arlen, 1);
            chk("t4_d_gnt", d_gnt, 0);
        end
        @(negedge clk); arready = 1; #1;
        chk("t4_d_gnt_acc", d_gnt, 1);
        chk("t4_arvalid_acc", arvalid, 1);
        d_req = 0;
        beat(32'hBAD, 1, 2'b10, 4'd1);
        chk("t5_rd_err", rd_err, 1);
        chk("t5_d_rvalid", d_rvalid, 1);
        chk("t5_d_rlast", d_rlast, 1);
        chk("t5_d_rdata", d_rdata, 32'hBAD);
        idle();
        chk("t5_rready_end", rready, 0);
        chk("t5_rd_err_end", rd_err, 0);

        // missing rlast on the expected last beat, late rlast afterwards
        @(negedge clk); i_req = 1; i_addr = 32'h40; i_len = 1;
        @(negedge clk); #1;
        chk("t6_i_gnt", i_gnt, 1);
        i_req = 0;
        beat(32'h61, 0, 2'b00, 4'd0);
        chk("t6_err_b1", rd_err, 0);
        beat(32'h62, 0, 2'b00, 4'd0);
        chk("t6_err_b2", rd_err, 1);
        beat(32'h63, 1, 2'b00, 4'd0);
        chk("t6_err_b3", rd_err, 1);
        chk("t6_i_rlast", i_rlast, 1);
        idle();
        chk("t6_rready_end", rready, 0);

        // reset during beat 2 of 4
        @(negedge clk); i_req = 1; i_addr = 32'h8000_0000; i_len = 3;
        @(negedge clk); #1;
        chk("t7_i_gnt", i_gnt, 1);
        i_req = 0;
        beat(32'h71, 0, 2'b00, 4'd0);
        chk("t7_b1", i_rvalid, 1);
        @(negedge clk); rvalid = 1; rdata = 32'h72; rst = 1; #1;
        chk("t7_arvalid", arvalid, 0);
        chk("t7_rready", rready, 0);
        chk("t7_i_rvalid", i_rvalid, 0);
        chk("t7_i_rdata", i_rdata, 0);
        chk("t7_araddr", araddr, 0);
        chk("t7_arlen", arlen, 0);
        chk("t7_rd_err", rd_err, 0);
        @(negedge clk); rst = 0; rvalid = 0; rdata = '0;
        @(negedge clk); i_req = 1; i_addr = 32'h44; i_len = 0;
        @(negedge clk); #1;
        chk("t7_new_arvalid", arvalid, 1);
        chk("t7_new_araddr", araddr, 32'h44);
        chk("t7_new_i_gnt", i_gnt, 1);
        i_req = 0;
        beat(32'h77, 1, 2'b00, 4'd0);
        chk("t7_new_i_rlast", i_rlast, 1);
        chk("t7_new_rd_err", rd_err, 0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
